sb_msg_tx_encoder: RTL and testbench

//  Sideband transmit end for LTSM message codes. Takes the 4-bit message code + valid from MBINIT substate wrappers (CAL, PARAM, ...).

---
 rtl/sb_msg_pkg.sv | 108 ++++++++++
 rtl/sb_msg_lut.sv | 21 ++
 rtl/sb_msg_tx_encoder.sv | 175 +++++++++++++++++
 tb/tb_sb_msg_tx_encoder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_msg_pkg.sv
// rtl/sb_msg_pkg.sv - sideband message tables, field positions and header builder (CP parity under SB_MSG_PARITY_EN)
package sb_msg_pkg;

  typedef enum logic [2:0] {
    SS_PARAM      = 3'd0,
    SS_CAL        = 3'd1,
    SS_REPAIRCLK  = 3'd2,
    SS_REPAIRVAL  = 3'd3,
    SS_REVERSALMB = 3'd4,
    SS_REPAIRMB   = 3'd5
  } substate_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_e;

  // Wrapper-side message codes; 0 means no message.
  localparam logic [3:0] MSG_NONE      = 4'd0;
  localparam logic [3:0] MSG_DONE_REQ  = 4'd1;
  localparam logic [3:0] MSG_DONE_RESP = 4'd2;
  localparam logic [3:0] MSG_INIT_REQ  = 4'd3;
  localparam logic [3:0] MSG_INIT_RESP = 4'd4;

  localparam logic [7:0] MSGCODE_MBINIT_REQ  = 8'h85;
  localparam logic [7:0] MSGCODE_MBINIT_RESP = 8'h8A;
  localparam logic [4:0] SB_OPCODE_MSG_NODATA = 5'h12;

  // Beat field bit positions.
  localparam int B0_SRCID_LSB   = 29;
  localparam int B0_MSGCODE_LSB = 14;
  localparam int B0_OPCODE_LSB  = 0;
  localparam int B1_DP_BIT      = 31;
  localparam int B1_CP_BIT      = 30;
  localparam int B1_DSTID_LSB   = 24;
  localparam int B1_MSGINFO_LSB = 8;
  localparam int B1_SUBCODE_LSB = 0;

  typedef struct packed {
    logic [7:0] msgcode;
    logic [7:0] subcode;
  } sb_msg_t;

  typedef struct packed {
    logic    hit;
    sb_msg_t msg;
  } lut_entry_t;

  typedef struct packed {
    logic [31:0] beat1;
    logic [31:0] beat0;
  } sb_hdr_t;

  // Each substate has a done subcode and optionally an init subcode; req/resp pick the msgcode.
  function automatic lut_entry_t sb_msg_lookup(input logic [2:0] substate, input logic [3:0] code);
    lut_entry_t e;
    logic       known;
    logic       has_init;
    logic [7:0] done_sub;
    logic [7:0] init_sub;
    e        = '0;
    known    = 1'b1;
    has_init = 1'b1;
    done_sub = 8'h00;
    init_sub = 8'h00;
    case (substate)
      SS_CAL:        begin done_sub = 8'h02; has_init = 1'b0; end
      SS_REPAIRCLK:  begin done_sub = 8'h08; init_sub = 8'h03; end
      SS_REPAIRVAL:  begin done_sub = 8'h0C; init_sub = 8'h09; end
      SS_REVERSALMB: begin done_sub = 8'h10; init_sub = 8'h0E; end
      SS_REPAIRMB:   begin done_sub = 8'h14; init_sub = 8'h11; end
      default:       known = 1'b0;
    endcase
    if (known) begin
      case (code)
        MSG_DONE_REQ:  e = '{hit: 1'b1, msg: '{MSGCODE_MBINIT_REQ, done_sub}};
        MSG_DONE_RESP: e = '{hit: 1'b1, msg: '{MSGCODE_MBINIT_RESP, done_sub}};
        MSG_INIT_REQ:  if (has_init) e = '{hit: 1'b1, msg: '{MSGCODE_MBINIT_REQ, init_sub}};
        MSG_INIT_RESP: if (has_init) e = '{hit: 1'b1, msg: '{MSGCODE_MBINIT_RESP, init_sub}};
        default:       e = '0;
      endcase
    end
    return e;
  endfunction

  // Assemble the two-beat message-without-data header; DP is always 0, msginfo is 0.
  function automatic sb_hdr_t sb_build_header(input logic [2:0] srcid, input logic [2:0] dstid,
                                              input sb_msg_t msg);
    sb_hdr_t h;
    h = '0;
    h.beat0[B0_SRCID_LSB +: 3]   = srcid;
    h.beat0[B0_MSGCODE_LSB +: 8] = msg.msgcode;
    h.beat0[B0_OPCODE_LSB +: 5]  = SB_OPCODE_MSG_NODATA;
    h.beat1[B1_DSTID_LSB +: 3]   = dstid;
    h.beat1[B1_MSGINFO_LSB +: 16] = 16'h0000;
    h.beat1[B1_SUBCODE_LSB +: 8] = msg.subcode;
    h.beat1[B1_DP_BIT]           = 1'b0;
`ifdef SB_MSG_PARITY_EN
    h.beat1[B1_CP_BIT] = ^{h.beat1, h.beat0};
`else
    h.beat1[B1_CP_BIT] = 1'b0;
`endif
    return h;
  endfunction

endpackage

// File: rtl/sb_msg_lut.sv
// rtl/sb_msg_lut.sv - combinational {substate,code} to {hit,msgcode,subcode} lookup
module sb_msg_lut
  import sb_msg_pkg::*;
(
  input  logic [2:0] i_substate,
  input  logic [3:0] i_code,
  output logic       o_hit,
  output logic [7:0] o_msgcode,
  output logic [7:0] o_subcode
);

  // Pure table lookup; a miss returns zeros with o_hit low.
  always_comb begin
    lut_entry_t e;
    e         = sb_msg_lookup(i_substate, i_code);
    o_hit     = e.hit;
    o_msgcode = e.msg.msgcode;
    o_subcode = e.msg.subcode;
  end

endmodule

// File: rtl/sb_msg_tx_encoder.sv
// rtl/sb_msg_tx_encoder.sv - LTSM message code to two-beat sideband header transmitter (CP parity under SB_MSG_PARITY_EN)
module sb_msg_tx_encoder
  import sb_msg_pkg::*;
#(
  parameter logic [2:0] SRCID     = 3'b001,
  parameter logic [2:0] DSTID     = 3'b101,
  parameter int         MAX_STALL = 1024
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [3:0]  i_TX_SbMessage,
  input  logic        i_msg_valid,
  input  logic [2:0]  i_substate,
  input  logic        i_sb_ready,
  input  logic        i_clr_err,
  output logic [31:0] o_sb_data,
  output logic        o_sb_valid,
  output logic        o_busy,
  output logic        o_falling_edge_busy,
  output logic        o_encode_err,
  output logic        o_drop,
  output logic        o_stall_err
);

  localparam int              CNT_W       = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(MAX_STALL);

  tx_state_e        state_q, state_d;
  sb_hdr_t          hdr_q, hdr_d;
  logic             pend_v_q, pend_v_d;
  sb_msg_t          pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic             valid_prev_q, valid_prev_d;
  logic [3:0]       last_code_q, last_code_d;
  logic             enc_err_q, enc_err_d;
  logic             drop_q, drop_d;

  logic             lut_hit;
  sb_msg_t          lut_msg;
  logic             req;
  logic             req_ok;
  logic             abort;
  logic [CNT_W-1:0] stall_inc;

  sb_msg_lut u_lut (
    .i_substate (i_substate),
    .i_code     (i_TX_SbMessage),
    .o_hit      (lut_hit),
    .o_msgcode  (lut_msg.msgcode),
    .o_subcode  (lut_msg.subcode)
  );

  // A level-valid only counts as a new request on its rising edge or when the code changes.
  assign req       = i_msg_valid && (i_TX_SbMessage != MSG_NONE) &&
                     (!valid_prev_q || (i_TX_SbMessage != last_code_q));
  assign req_ok    = req && lut_hit;
  assign stall_inc = stall_cnt_q + 1'b1;

  // Next-state: launch/queue/drop decisions, beat sequencing and stall abort.
  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    pend_v_d     = pend_v_q;
    pend_d       = pend_q;
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q && !i_clr_err;
    valid_prev_d = i_msg_valid;
    last_code_d  = req ? i_TX_SbMessage : last_code_q;
    enc_err_d    = req && !lut_hit;
    drop_d       = 1'b0;
    abort        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if (pend_v_q) begin
          // Pending entry goes first; a simultaneous new request takes over the freed slot.
          hdr_d    = sb_build_header(SRCID, DSTID, pend_q);
          state_d  = ST_BEAT0;
          pend_v_d = req_ok;
          if (req_ok) pend_d = lut_msg;
        end else if (req_ok) begin
          hdr_d   = sb_build_header(SRCID, DSTID, lut_msg);
          state_d = ST_BEAT0;
        end
      end
      ST_BEAT0, ST_BEAT1: begin
        if (i_sb_ready) begin
          stall_cnt_d = '0;
          state_d     = (state_q == ST_BEAT0) ? ST_BEAT1 : ST_GAP;
        end else if (stall_inc == STALL_LIMIT) begin
          abort = 1'b1;
        end else begin
          stall_cnt_d = stall_inc;
        end
      end
      ST_GAP: begin
        stall_cnt_d = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      // Abandon the message and anything waiting behind it; no falling-edge pulse.
      state_d     = ST_IDLE;
      stall_cnt_d = '0;
      pend_v_d    = 1'b0;
      stall_err_d = 1'b1;
      drop_d      = req_ok;
    end else if (state_q != ST_IDLE && req_ok) begin
      if (pend_v_q) begin
        drop_d = 1'b1;
      end else begin
        pend_v_d = 1'b1;
        pend_d   = lut_msg;
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hdr_q        <= '0;
      pend_v_q     <= 1'b0;
      pend_q       <= '0;
      stall_cnt_q  <= '0;
      stall_err_q  <= 1'b0;
      valid_prev_q <= 1'b0;
      last_code_q  <= '0;
      enc_err_q    <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      pend_v_q     <= pend_v_d;
      pend_q       <= pend_d;
      stall_cnt_q  <= stall_cnt_d;
      stall_err_q  <= stall_err_d;
      valid_prev_q <= valid_prev_d;
      last_code_q  <= last_code_d;
      enc_err_q    <= enc_err_d;
      drop_q       <= drop_d;
    end
  end

  // Link outputs decode from state; data is zero whenever no beat is offered.
  always_comb begin
    o_sb_valid          = 1'b0;
    o_busy              = 1'b0;
    o_falling_edge_busy = 1'b0;
    o_sb_data           = '0;
    case (state_q)
      ST_BEAT0: begin
        o_sb_valid = 1'b1;
        o_busy     = 1'b1;
        o_sb_data  = hdr_q.beat0;
      end
      ST_BEAT1: begin
        o_sb_valid = 1'b1;
        o_busy     = 1'b1;
        o_sb_data  = hdr_q.beat1;
      end
      ST_GAP:  o_falling_edge_busy = 1'b1;
      default: ;
    endcase
  end

  assign o_encode_err = enc_err_q;
  assign o_drop       = drop_q;
  assign o_stall_err  = stall_err_q;

endmodule

// File: tb/tb_sb_msg_tx_encoder.sv
// tb/tb_sb_msg_tx_encoder.sv - self-checking bench for sb_msg_tx_encoder (expects SB_MSG_PARITY_EN as built)
module tb_sb_msg_tx_encoder;

  localparam int MAX_STALL = 8;
`ifdef SB_MSG_PARITY_EN
  localparam logic [31:0] EXP_CAL_B1 = 32'h45000002;
`else
  localparam logic [31:0] EXP_CAL_B1 = 32'h05000002;
`endif

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  code = 4'd0;
  logic        msg_valid = 1'b0;
  logic [2:0]  substate = 3'd0;
  logic        sb_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] o_sb_data;
  logic        o_sb_valid, o_busy, o_falling_edge_busy, o_encode_err, o_drop, o_stall_err;

  always #5 CLK = ~CLK;

  sb_msg_tx_encoder #(.MAX_STALL(MAX_STALL)) dut (
    .CLK                 (CLK),
    .rst                 (rst),
    .i_TX_SbMessage      (code),
    .i_msg_valid         (msg_valid),
    .i_substate          (substate),
    .i_sb_ready          (sb_ready),
    .i_clr_err           (clr_err),
    .o_sb_data           (o_sb_data),
    .o_sb_valid          (o_sb_valid),
    .o_busy              (o_busy),
    .o_falling_edge_busy (o_falling_edge_busy),
    .o_encode_err        (o_encode_err),
    .o_drop              (o_drop),
    .o_stall_err         (o_stall_err)
  );

  int tests = 0;
  int fails = 0;
  int feb_cnt = 0, drop_cnt = 0, enc_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Mapping table: substate, code, msgcode, subcode.
  int lut_tbl [0:17][0:3] = '{
    '{1, 1, 'h85, 'h02}, '{1, 2, 'h8A, 'h02},
    '{2, 3, 'h85, 'h03}, '{2, 4, 'h8A, 'h03}, '{2, 1, 'h85, 'h08}, '{2, 2, 'h8A, 'h08},
    '{3, 3, 'h85, 'h09}, '{3, 4, 'h8A, 'h09}, '{3, 1, 'h85, 'h0C}, '{3, 2, 'h8A, 'h0C},
    '{4, 3, 'h85, 'h0E}, '{4, 4, 'h8A, 'h0E}, '{4, 1, 'h85, 'h10}, '{4, 2, 'h8A, 'h10},
    '{5, 3, 'h85, 'h11}, '{5, 4, 'h8A, 'h11}, '{5, 1, 'h85, 'h14}, '{5, 2, 'h8A, 'h14}
  };

  function automatic void tb_lookup(input logic [2:0] s, input logic [3:0] c,
                                    output bit hit, output logic [7:0] mc, output logic [7:0] sc);
    hit = 0; mc = 0; sc = 0;
    for (int i = 0; i < 18; i++) begin
      if (lut_tbl[i][0] == int'(s) && lut_tbl[i][1] == int'(c)) begin
        hit = 1; mc = 8'(lut_tbl[i][2]); sc = 8'(lut_tbl[i][3]);
      end
    end
  endfunction

  // Returns {beat1, beat0}.
  function automatic logic [63:0] tb_hdr(input logic [7:0] mc, input logic [7:0] sc);
    logic [31:0] b0, b1;
    b0 = (32'd1 << 29) | ({24'd0, mc} << 14) | 32'h12;
    b1 = (32'd5 << 24) | {24'd0, sc};
`ifdef SB_MSG_PARITY_EN
    if (^{b0, b1}) b1 = b1 | 32'h4000_0000;
`endif
    return {b1, b0};
  endfunction

  // Model: queue of accepted headers (head is in flight, second is the waiting one).
  logic [63:0] mq[$];
  bit          m_launched = 0, m_beat = 0, m_gap = 0, m_err = 0, m_prev_v = 0, m_enc = 0, m_drop = 0;
  int          m_stall = 0;
  logic [3:0]  m_last = 0;

  always @(posedge CLK) begin
    bit         req, hit, valid_now, gap_now, abort;
    logic [7:0] mc, sc;
    if (rst) begin
      mq.delete();
      m_launched = 0; m_beat = 0; m_gap = 0; m_err = 0; m_prev_v = 0;
      m_enc = 0; m_drop = 0; m_stall = 0; m_last = 0;
    end else begin
      req = msg_valid && code != 0 && (!m_prev_v || code != m_last);
      tb_lookup(substate, code, hit, mc, sc);
      m_prev_v = msg_valid;
      if (req) m_last = code;
      m_enc  = req && !hit;
      m_drop = 0;
      valid_now = m_launched && !m_gap;
      gap_now   = m_gap;
      abort     = 0;
      if (valid_now) begin
        if (sb_ready) begin
          m_stall = 0;
          if (!m_beat) m_beat = 1; else m_gap = 1;
        end else begin
          m_stall++;
          if (m_stall == MAX_STALL) abort = 1;
        end
      end else begin
        m_stall = 0;
      end
      if (abort) begin
        mq.delete();
        m_launched = 0; m_gap = 0; m_stall = 0; m_err = 1;
        if (req && hit) m_drop = 1;
      end else begin
        if (clr_err) m_err = 0;
        if (req && hit) begin
          if (mq.size() < 2) mq.push_back(tb_hdr(mc, sc));
          else m_drop = 1;
        end
        if (gap_now) begin
          void'(mq.pop_front());
          m_gap = 0; m_launched = 0;
        end else if (!valid_now && mq.size() > 0) begin
          m_launched = 1; m_beat = 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    bit          ev;
    logic [31:0] ed;
    ev = m_launched && !m_gap;
    ed = 32'h0;
    if (ev && mq.size() > 0) ed = m_beat ? mq[0][63:32] : mq[0][31:0];
    check1("sb_valid", o_sb_valid, ev);
    check1("busy", o_busy, ev);
    check32("sb_data", o_sb_data, ed);
    check1("falling_edge_busy", o_falling_edge_busy, m_gap);
    check1("encode_err", o_encode_err, m_enc);
    check1("drop", o_drop, m_drop);
    check1("stall_err", o_stall_err, m_err);
    if (o_falling_edge_busy) feb_cnt++;
    if (o_drop) drop_cnt++;
    if (o_encode_err) enc_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    logic [63:0] h;
    int          f0, d0, e0;

    h = tb_hdr(8'h85, 8'h02);
    check32("model_cal_req_b0", h[31:0], 32'h20214012);
    check32("model_cal_req_b1", h[63:32], EXP_CAL_B1);
    h = tb_hdr(8'h8A, 8'h02);
    check32("model_cal_resp_b0", h[31:0], 32'h20228012);

    cyc(3);
    check1("reset_valid", o_sb_valid, 1'b0);
    check32("reset_data", o_sb_data, 32'h0);
    check1("reset_stall_err", o_stall_err, 1'b0);
    rst = 1'b0;
    cyc(2);

    // CAL done request, ready always high.
    substate = 3'd1; sb_ready = 1'b1; code = 4'd1; msg_valid = 1'b1;
    cyc(1); check32("t1_beat0", o_sb_data, 32'h20214012);
    cyc(1); check32("t1_beat1", o_sb_data, EXP_CAL_B1);
    cyc(1); check1("t1_feb", o_falling_edge_busy, 1'b1); check1("t1_busy_low", o_busy, 1'b0);
    cyc(1); check1("t1_feb_once", o_falling_edge_busy, 1'b0);
    msg_valid = 1'b0; code = 4'd0;
    cyc(2);

    // Ready low for three cycles on beat0: data held.
    code = 4'd2; msg_valid = 1'b1; sb_ready = 1'b0;
    cyc(1); check32("t3_hold0", o_sb_data, 32'h20228012);
    cyc(1); check32("t3_hold1", o_sb_data, 32'h20228012);
    cyc(1); check32("t3_hold2", o_sb_data, 32'h20228012); check1("t3_busy", o_busy, 1'b1);
    cyc(1); sb_ready = 1'b1;
    cyc(5); msg_valid = 1'b0; code = 4'd0;
    check1("t3_no_err", o_stall_err, 1'b0);
    cyc(2);

    // Ready stuck low: abort after MAX_STALL; set beats a concurrent clear.
    f0 = feb_cnt;
    code = 4'd1; msg_valid = 1'b1; sb_ready = 1'b0; clr_err = 1'b1;
    cyc(9);
    check1("t3_stall_err_set", o_stall_err, 1'b1);
    check1("t3_abort_valid", o_sb_valid, 1'b0);
    clr_err = 1'b0; msg_valid = 1'b0; code = 4'd0;
    cyc(2); check1("t3_stall_sticky", o_stall_err, 1'b1);
    check32("t3_no_pulse", 32'(feb_cnt - f0), 32'd0);
    clr_err = 1'b1; cyc(1); clr_err = 1'b0; cyc(1);
    check1("t3_stall_cleared", o_stall_err, 1'b0);

    // Codes 1, 2, 1 during one send: one queued, one dropped.
    f0 = feb_cnt; d0 = drop_cnt;
    sb_ready = 1'b1; msg_valid = 1'b1; code = 4'd1;
    cyc(1); code = 4'd2;
    cyc(1); code = 4'd1;
    cyc(1); msg_valid = 1'b0; code = 4'd0;
    cyc(12);
    check32("t4_pulses", 32'(feb_cnt - f0), 32'd2);
    check32("t4_drops", 32'(drop_cnt - d0), 32'd1);

    // Level valid held: constant code sent once, code change sent again, code 15 unmapped.
    f0 = feb_cnt; e0 = enc_cnt;
    msg_valid = 1'b1; code = 4'd2;
    cyc(8); check32("t5_once", 32'(feb_cnt - f0), 32'd1);
    code = 4'd1;
    cyc(8); check32("t5_again", 32'(feb_cnt - f0), 32'd2);
    code = 4'd15;
    cyc(1); check1("t5_enc_err", o_encode_err, 1'b1);
    cyc(6);
    check32("t5_enc_cnt", 32'(enc_cnt - e0), 32'd1);
    check32("t5_nothing_sent", 32'(feb_cnt - f0), 32'd2);
    msg_valid = 1'b0; code = 4'd0;
    substate = 3'd2; cyc(1);
    msg_valid = 1'b1; code = 4'd3;
    cyc(1); check32("t5_repairclk_b0", o_sb_data, 32'h20214012);
    cyc(4); msg_valid = 1'b0; code = 4'd0; substate = 3'd1;
    cyc(2);

    // Reset during BEAT1, then a clean send.
    code = 4'd2; msg_valid = 1'b1; sb_ready = 1'b1;
    cyc(1); cyc(1);
    check1("t6_in_beat1", o_sb_valid, 1'b1);
    sb_ready = 1'b0; rst = 1'b1;
    cyc(1);
    check1("t6_rst_valid", o_sb_valid, 1'b0);
    check1("t6_rst_busy", o_busy, 1'b0);
    rst = 1'b0; msg_valid = 1'b0; code = 4'd0; sb_ready = 1'b1;
    cyc(1);
    code = 4'd1; msg_valid = 1'b1;
    cyc(1); check32("t6_after_b0", o_sb_data, 32'h20214012);
    cyc(1); check32("t6_after_b1", o_sb_data, EXP_CAL_B1);
    cyc(3); msg_valid = 1'b0; code = 4'd0;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
